// File: rtl/drawbridge_pkg.sv
// Shared definitions for the drawbridge lift sequencer: state encodings,
// on/off levels, default timing values and the state-to-output decode.
package drawbridge_pkg;

    // Sequencer state encodings (3'b110 is unused and treated as a fault)
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_WARN  = 3'b001;
    localparam logic [2:0] ST_CLEAR = 3'b010;
    localparam logic [2:0] ST_RAISE = 3'b011;
    localparam logic [2:0] ST_OPEN  = 3'b100;
    localparam logic [2:0] ST_LOWER = 3'b101;
    localparam logic [2:0] ST_FAULT = 3'b111;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    // Default sizing and timing
    localparam int DEF_CAR_CNT_W     = 4;
    localparam int DEF_TIMER_W       = 8;
    localparam int DEF_WARN_CYCLES   = 8;
    localparam int DEF_CLEAR_TIMEOUT = 32;
    localparam int DEF_MOTOR_TIMEOUT = 16;

    typedef struct packed {
        logic car_barrier;
        logic alert;
        logic motor_up;
        logic motor_down;
        logic bridge_s;
        logic boat_go;
        logic fault;
    } ctrl_out_t;

    // Moore output decode: every output depends on the state alone
    function automatic ctrl_out_t decode_outputs(input logic [2:0] state);
        ctrl_out_t o;
        o = '{default: OFF};
        case (state)
            ST_IDLE: begin
            end
            ST_WARN, ST_CLEAR: begin
                o.alert       = ON;
                o.car_barrier = ON;
            end
            ST_RAISE: begin
                o.alert       = ON;
                o.car_barrier = ON;
                o.motor_up    = ON;
            end
            ST_OPEN: begin
                o.alert       = ON;
                o.car_barrier = ON;
                o.bridge_s    = ON;
                o.boat_go     = ON;
            end
            ST_LOWER: begin
                o.alert       = ON;
                o.car_barrier = ON;
                o.motor_down  = ON;
            end
            default: begin
                o.alert       = ON;
                o.car_barrier = ON;
                o.fault       = ON;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/car_counter.sv
// Saturating up/down counter tracking how many cars are on the deck.
module car_counter
    import drawbridge_pkg::*;
#(
    parameter int CNT_W = DEF_CAR_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a lone pulse moves the count, clamped at both ends
    always_comb begin
        count_d = count_q;
        if (i_inc && !i_dec && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end else if (i_dec && !i_inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/bridge_lift_sequencer.sv
// Drawbridge lift sequencer: warn, clear deck, raise, pass boat, lower,
// reopen, with phase timeouts and limit-switch sanity checks feeding a
// sticky fault state.
module bridge_lift_sequencer
    import drawbridge_pkg::*;
#(
    parameter int CAR_CNT_W     = DEF_CAR_CNT_W,
    parameter int TIMER_W       = DEF_TIMER_W,
    parameter int WARN_CYCLES   = DEF_WARN_CYCLES,
    parameter int CLEAR_TIMEOUT = DEF_CLEAR_TIMEOUT,
    parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_carIn,
    input  logic                 i_carOut,
    input  logic                 i_boatClose,
    input  logic                 i_boatHere,
    input  logic                 i_upLimit,
    input  logic                 i_downLimit,
    output logic                 o_carBarrier,
    output logic                 o_alert,
    output logic                 o_motorUp,
    output logic                 o_motorDown,
    output logic                 o_bridge_s,
    output logic                 o_boatGo,
    output logic                 o_fault,
    output logic [CAR_CNT_W-1:0] o_carCount
);

    // Timer reload values: a phase of N cycles starts at N-1 and ends at 0
    localparam logic [TIMER_W-1:0] WARN_LOAD  = TIMER_W'(WARN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CLEAR_LOAD = TIMER_W'(CLEAR_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] MOTOR_LOAD = TIMER_W'(MOTOR_TIMEOUT - 1);

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic [CAR_CNT_W-1:0] car_count;
    logic                 boat_req;
    logic                 timer_done;
    ctrl_out_t            ctrl;

    car_counter #(
        .CNT_W (CAR_CNT_W)
    ) u_car_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (i_carIn),
        .i_dec   (i_carOut),
        .o_count (car_count)
    );

    assign boat_req   = i_boatClose | i_boatHere;
    assign timer_done = (timer_q == '0);

    // Next-state logic; both limits high overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!i_downLimit) begin
                    state_d = ST_FAULT;
                end else if (boat_req) begin
                    state_d = ST_WARN;
                end
            end
            ST_WARN: begin
                if (!boat_req) begin
                    state_d = ST_IDLE;
                end else if (timer_done) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!boat_req) begin
                    state_d = ST_IDLE;
                end else if (car_count == '0) begin
                    state_d = ST_RAISE;
                end else if (timer_done) begin
                    state_d = ST_FAULT;
                end
            end
            ST_RAISE: begin
                if (i_upLimit) begin
                    state_d = ST_OPEN;
                end else if (timer_done) begin
                    state_d = ST_FAULT;
                end
            end
            ST_OPEN: begin
                if (!boat_req) begin
                    state_d = ST_LOWER;
                end
            end
            ST_LOWER: begin
                if (i_downLimit) begin
                    state_d = ST_IDLE;
                end else if (timer_done) begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
        if (i_upLimit && i_downLimit) begin
            state_d = ST_FAULT;
        end
    end

    // Phase timer: reload on every state change, otherwise count down to 0
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_WARN:            timer_d = WARN_LOAD;
                ST_CLEAR:           timer_d = CLEAR_LOAD;
                ST_RAISE, ST_LOWER: timer_d = MOTOR_LOAD;
                default:            timer_d = '0;
            endcase
        end else if (!timer_done) begin
            timer_d = timer_q - 1'b1;
        end
    end

    // State and timer registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign ctrl         = decode_outputs(state_q);
    assign o_carBarrier = ctrl.car_barrier;
    assign o_alert      = ctrl.alert;
    assign o_motorUp    = ctrl.motor_up;
    assign o_motorDown  = ctrl.motor_down;
    assign o_bridge_s   = ctrl.bridge_s;
    assign o_boatGo     = ctrl.boat_go;
    assign o_fault      = ctrl.fault;
    assign o_carCount   = car_count;

endmodule

// File: doc/bridge_lift_sequencer.md
# bridge_lift_sequencer

Sequencing controller for the drawbridge: it owns the car-occupancy count, the car barrier, the warning alert, and the lift motor. It runs the full cycle from an approaching boat through warn, clear-deck, raise, boat-pass, lower and reopen. It replaces per-cycle input decoding with a timed, limit-switch-checked state machine. A sticky fault state covers a deck that does not clear and motor/limit-switch failures.

## Interface
Parameters:
- CAR_CNT_W, 4, width of the car occupancy counter
- TIMER_W, 8, width of the phase timer
- WARN_CYCLES, 8, cycles the alert runs before deck clearing starts (1..2^TIMER_W)
- CLEAR_TIMEOUT, 32, maximum cycles to wait for an empty deck
- MOTOR_TIMEOUT, 16, maximum cycles for a raise or lower to reach its limit switch

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_carIn  in  1  one-cycle pulse, car entered the deck
- i_carOut  in  1  one-cycle pulse, car left the deck
- i_boatClose  in  1  level, boat approaching
- i_boatHere  in  1  level, boat at the bridge
- i_upLimit  in  1  level, bridge fully raised
- i_downLimit  in  1  level, bridge fully lowered
- o_carBarrier  out  1  1 = barrier closed to entering cars
- o_alert  out  1  warning light/siren
- o_motorUp  out  1  drive lift upward
- o_motorDown  out  1  drive lift downward
- o_bridge_s  out  1  1 = bridge open to boats
- o_boatGo  out  1  clearance signal to the boat
- o_fault  out  1  sticky fault indication
- o_carCount  out  CAR_CNT_W  current deck occupancy

## Operation
- Car counter: +1 on i_carIn, −1 on i_carOut. Simultaneous pulses leave the count unchanged. It saturates at 2^CAR_CNT_W−1 and at 0. It counts in every state, including while the barrier is closed.
- Boat request: boat_req = i_boatClose | i_boatHere.
- Moore FSM. Outputs decode from the state register only:
  - IDLE: all outputs 0. boat_req → WARN.
  - WARN: alert=1, barrier=1. The timer runs WARN_CYCLES. When it expires → CLEAR. If boat_req drops → IDLE.
  - CLEAR: alert=1, barrier=1.
    - o_carCount==0 → RAISE.
    - CLEAR_TIMEOUT expires with count nonzero → FAULT.
    - boat_req drops → IDLE.
    - If count==0 and boat_req drops in the same cycle, IDLE wins.
  - RAISE: alert=1, barrier=1, motorUp=1. i_upLimit → OPEN. MOTOR_TIMEOUT expires → FAULT.
  - OPEN: alert=1, barrier=1, bridge_s=1, boatGo=1. Once both boat inputs are low → LOWER.
  - LOWER: alert=1, barrier=1, motorDown=1. i_downLimit → IDLE. MOTOR_TIMEOUT expires → FAULT.
  - FAULT: alert=1, barrier=1, fault=1, motors 0. Only reset leaves FAULT.
- Limit switch checks:
  - i_upLimit and i_downLimit both high in any state → FAULT.
  - i_downLimit low in IDLE → FAULT, because the bridge is not seated.
- Once RAISE is entered, the cycle always completes through OPEN and LOWER; boat inputs are ignored until OPEN.
- A boat that is still present when LOWER completes goes IDLE → WARN on the next cycle, so the barrier opens for exactly one cycle.

## Timing
- Reset (asynchronous): state=IDLE, timer=0, count=0. Every output is 0.
- The FSM and counter update on the rising edge of i_clk. Outputs change in the same cycle as the state, i.e. one cycle after the sampled input that caused the change.
- Phase timer: loaded with N−1 on state entry, decremented each cycle, and expires at 0, so a timed state lasts exactly N cycles.
- WARN therefore lasts exactly WARN_CYCLES cycles.
- CLEAR lasts at least 1 cycle. An empty deck on entry means RAISE on the next edge.
- A limit switch seen on cycle k of RAISE or LOWER takes precedence over a timeout on that same cycle.
- Counter: o_carCount reflects a pulse on the next edge.
- The FSM compares the registered count, so a car leaving on cycle k enables RAISE at edge k+2 at the earliest.

## Structure
- Shared package drawbridge_pkg holds:
  - the 3-bit state encodings: IDLE=000, WARN=001, CLEAR=010, RAISE=011, OPEN=100, LOWER=101, FAULT=111;
  - the on/off constants;
  - the default timing values.
- Sub-module car_counter (up/down, saturating, CAR_CNT_W wide) is instantiated once. It has its own clock and reset, matching this block.
- The FSM, the phase timer, and the output decode live in the top module.

## Test plan
- Reset, then i_boatClose=1 with count 0 and downLimit=1:
  - WARN for exactly 8 cycles, CLEAR for 1, then RAISE.
  - Assert upLimit → OPEN with bridge_s=1 and boatGo=1.
  - Drop the boat inputs → LOWER.
  - Assert downLimit → IDLE with all outputs 0.
- 3 cars in, boat arrives: the FSM holds CLEAR until 3 carOut pulses bring the count to 0, then RAISE two edges after the last pulse.
- Car count 1, no exit: FAULT on the 32nd CLEAR cycle. fault=1, barrier=1 and motors 0 until i_reset.
- RAISE with upLimit never asserted: FAULT after exactly 16 cycles. Also check that upLimit and downLimit both high in OPEN → FAULT on the next edge.
- Counter edge cases: simultaneous carIn/carOut leaves the count unchanged; 16 carIn pulses saturate at 15; carOut at 0 stays 0.
- Boat leaves during WARN (cycle 4) → IDLE with alert 0. A mid-RAISE asynchronous reset clears motorUp and all other outputs immediately, without waiting for a clock edge.
